mem_access_stage: RTL and testbench

- Memory/writeback stage that consumes the execute stage's results (result, destination register, address, store flag) and performs the actual data-memory access.
- Issues load/store requests to the data-memory port with a valid/ready handshake and formats returned load data.
- Presents one registered writeback record per instruction to the register file.
- Back-pressures execute while a memory transaction is outstanding.

---
 rtl/mem_access_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory/writeback stage. Takes the execute stage's result, address and
//   memory-op flags, issues aligned load/store requests on a valid/ready data
//   memory port, formats load data, and presents one registered writeback
//   record per instruction. Execute is back-pressured while a memory
//   transaction is outstanding.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new instruction; non-memory ops and faults finish here
//   REQ   | request held on dmem_req_* until dmem_req_ready
//   RESP  | load issued, waiting for dmem_resp_valid (or the timeout)
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   ex_*              instruction offered by execute; ex_ready high only in IDLE
//   is_flush          kills the instruction currently offered
//   dmem_req_*        registered request: doubleword address, we, lane data/strobes
//   dmem_resp_*       load response, aligned 64-bit doubleword
//   wb_*              one-cycle writeback record (valid, enable, rd, data, fault)

module mem_access_stage #(
  parameter int XLEN         = 64,
  parameter int REG_W        = 5,
  parameter int RESP_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             is_flush,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [REG_W-1:0] ex_rd,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic [XLEN-1:0]  dmem_req_addr,
  output logic             dmem_req_we,
  output logic [XLEN-1:0]  dmem_req_wdata,
  output logic [7:0]       dmem_req_wstrb,
  input  logic             dmem_resp_valid,
  input  logic [XLEN-1:0]  dmem_resp_data,
  output logic             wb_valid,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [1:0]       wb_fault
);

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ALIGN   = 2'd1;
  localparam logic [1:0] FAULT_FUNCT3  = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

  // Counter only needs to hold 0 .. RESP_TIMEOUT-1.
  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [2:0]       lat_f3;
  logic [2:0]       lat_off;
  logic [REG_W-1:0] lat_rd;
  logic [CNT_W-1:0] resp_cnt;

  logic             accept;
  logic             is_mem;
  logic             illegal;
  logic             misalign;
  logic [2:0]       off;
  logic [XLEN-1:0]  st_wdata;
  logic [7:0]       st_wstrb;
  logic [XLEN-1:0]  ld_data;
  logic             timeout_hit;

  logic             wb_fire;
  logic             wb_en_nx;
  logic [REG_W-1:0] wb_rd_nx;
  logic [XLEN-1:0]  wb_data_nx;
  logic [1:0]       wb_fault_nx;
  logic             lat_load;

  // ------------------------------------------------------------------
  // Decode of the offered instruction
  // ------------------------------------------------------------------
  always_comb begin
    off      = ex_addr[2:0];
    is_mem   = ex_is_load | ex_is_store;
    illegal  = (ex_funct3 == 3'd7) || (ex_is_store && ex_funct3[2]);
    // funct3[1:0] encodes the access size for both signed and unsigned forms
    case (ex_funct3[1:0])
      2'd1:    misalign = off[0];
      2'd2:    misalign = (off[1:0] != 2'b00);
      2'd3:    misalign = (off != 3'b000);
      default: misalign = 1'b0;
    endcase
    st_wdata = ex_result << {off, 3'b000};
    case (ex_funct3[1:0])
      2'd0:    st_wstrb = 8'h01 << off;
      2'd1:    st_wstrb = 8'h03 << off;
      2'd2:    st_wstrb = 8'h0F << off;
      default: st_wstrb = 8'hFF;
    endcase
  end

  // ------------------------------------------------------------------
  // Load lane select and extension
  // ------------------------------------------------------------------
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;

  always_comb begin
    ld_b = dmem_resp_data[{lat_off, 3'b000} +: 8];
    ld_h = dmem_resp_data[{lat_off[2:1], 4'b0000} +: 16];
    ld_w = dmem_resp_data[{lat_off[2], 5'b00000} +: 32];
    case (lat_f3)
      3'd0:    ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'd1:    ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'd2:    ld_data = {{(XLEN-32){ld_w[31]}}, ld_w};
      3'd4:    ld_data = {{(XLEN-8){1'b0}}, ld_b};
      3'd5:    ld_data = {{(XLEN-16){1'b0}}, ld_h};
      3'd6:    ld_data = {{(XLEN-32){1'b0}}, ld_w};
      default: ld_data = dmem_resp_data;
    endcase
  end

  assign timeout_hit = (RESP_TIMEOUT > 0) && (resp_cnt == CNT_LAST);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // ------------------------------------------------------------------
  // FSM: next state and outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_nx       = state;
    ex_ready       = (state == ST_IDLE);
    dmem_req_valid = (state == ST_REQ);
    accept         = ex_valid && (state == ST_IDLE) && !is_flush;
    wb_fire        = 1'b0;
    wb_en_nx       = 1'b0;
    wb_rd_nx       = lat_rd;
    wb_data_nx     = '0;
    wb_fault_nx    = FAULT_NONE;
    lat_load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wb_rd_nx = ex_rd;
          if (!is_mem) begin
            wb_fire    = 1'b1;
            wb_en_nx   = (ex_rd != '0);
            wb_data_nx = ex_result;
          end else if (illegal) begin
            wb_fire     = 1'b1;
            wb_fault_nx = FAULT_FUNCT3;
          end else if (misalign) begin
            wb_fire     = 1'b1;
            wb_fault_nx = FAULT_ALIGN;
          end else begin
            lat_load = 1'b1;
            state_nx = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          if (dmem_req_we) begin
            // posted store: retire without waiting for a response
            wb_fire  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // a response in the timeout cycle takes priority
        if (dmem_resp_valid) begin
          wb_fire    = 1'b1;
          wb_en_nx   = (lat_rd != '0);
          wb_data_nx = ld_data;
          state_nx   = ST_IDLE;
        end else if (timeout_hit) begin
          wb_fire     = 1'b1;
          wb_fault_nx = FAULT_TIMEOUT;
          state_nx    = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Request, latch, counter and writeback registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_f3         <= '0;
      lat_off        <= '0;
      lat_rd         <= '0;
      resp_cnt       <= '0;
      dmem_req_addr  <= '0;
      dmem_req_we    <= 1'b0;
      dmem_req_wdata <= '0;
      dmem_req_wstrb <= '0;
      wb_valid       <= 1'b0;
      wb_en          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_fault       <= '0;
    end else begin
      if (lat_load) begin
        lat_f3         <= ex_funct3;
        lat_off        <= off;
        lat_rd         <= ex_rd;
        dmem_req_addr  <= {ex_addr[XLEN-1:3], 3'b000};
        dmem_req_we    <= ex_is_store;
        dmem_req_wdata <= ex_is_store ? st_wdata : '0;
        dmem_req_wstrb <= ex_is_store ? st_wstrb : 8'h00;
      end
      if (state == ST_REQ)       resp_cnt <= '0;
      else if (state == ST_RESP) resp_cnt <= resp_cnt + CNT_W'(1);
      wb_valid <= wb_fire;
      wb_en    <= wb_en_nx;
      if (wb_fire) begin
        wb_rd    <= wb_rd_nx;
        wb_data  <= wb_data_nx;
        wb_fault <= wb_fault_nx;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Drives mem_access_stage one instruction at a time, acts as the data memory,
//   and compares every cycle against a transaction-level model: expected
//   writeback records with the cycle they must appear, the cycle window in
//   which a request must be presented, and the window in which ex_ready is low.

module tb_mem_access_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, is_flush, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_result;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_data;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  wb_fault;

  mem_access_stage #(.XLEN(64), .REG_W(5), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .is_flush(is_flush),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_result(ex_result), .ex_rd(ex_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    bit         en;
    logic [4:0] rd;
    logic [63:0] data;
    logic [1:0] fault;
  } rec_t;

  rec_t sb[$];
  bit   chk_en = 1'b0;
  int   busy_lo = 1, busy_hi = 0;
  int   req_lo = 1, req_hi = 0;
  logic [63:0] exp_addr, exp_wdata;
  logic        exp_we;
  logic [7:0]  exp_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int o, input logic [63:0] d);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++)
      v = v | (((d >> (8 * (o + i))) & 64'hFF) << (8 * i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input int o);
    return d << (8 * o);
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input int o);
    logic [15:0] m;
    m = 16'((1 << (1 << f3[1:0])) - 1) << o;
    return m[7:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_ready", {63'd0, ex_ready}, {63'd0, !(cyc >= busy_lo && cyc <= busy_hi)});
      chk("req_valid", {63'd0, dmem_req_valid}, {63'd0, (cyc >= req_lo && cyc <= req_hi)});
      if (dmem_req_valid && cyc >= req_lo && cyc <= req_hi) begin
        chk("req_addr", dmem_req_addr, exp_addr);
        chk("req_we", {63'd0, dmem_req_we}, {63'd0, exp_we});
        chk("req_wdata", dmem_req_wdata, exp_wdata);
        chk("req_wstrb", {56'd0, dmem_req_wstrb}, {56'd0, exp_wstrb});
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL wb_missing cycle=%0d actual=no_wb required_cycle=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (wb_valid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected cycle=%0d actual=wb_valid required=no_wb", cyc);
        end else begin
          rec_t r;
          r = sb.pop_front();
          chk("wb_en", {63'd0, wb_en}, {63'd0, r.en});
          chk("wb_fault", {62'd0, wb_fault}, {62'd0, r.fault});
          if (r.en) begin
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, r.rd});
            chk("wb_data", wb_data, r.data);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] data,
                       input logic [4:0] rd, input int rw, input int sw,
                       input logic [63:0] rdata, input bit flush);
    int a, n, o;
    rec_t r;
    bit legal;
    a = cyc;
    o = int'(addr[2:0]);
    ex_valid = 1'b1; is_flush = flush; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_result = data; ex_rd = rd;
    if (!ld && !st) begin
      dmem_req_ready  = 1'($urandom_range(0, 1));
      dmem_resp_valid = 1'($urandom_range(0, 1));
    end
    legal = 1'b0;
    if (!flush) begin
      n = 1 << f3[1:0];
      r.cyc = a + 1; r.en = 1'b0; r.rd = rd; r.data = 64'd0; r.fault = 2'd0;
      if (!ld && !st) begin
        r.en = (rd != 5'd0);
        r.data = data;
      end else if (f3 == 3'd7 || (st && f3 >= 3'd4)) begin
        r.fault = 2'd2;
      end else if (o % n != 0) begin
        r.fault = 2'd1;
      end else begin
        legal = 1'b1;
        exp_addr  = addr & ~64'h7;
        exp_we    = st;
        exp_wdata = st ? model_wdata(data, o) : 64'd0;
        exp_wstrb = st ? model_wstrb(f3, o) : 8'h00;
        req_lo = a + 1;
        req_hi = a + 1 + rw;
        if (st) r.cyc = a + 2 + rw;
        else if (sw >= TO) begin
          r.cyc = a + 2 + rw + TO;
          r.fault = 2'd3;
        end else begin
          r.cyc = a + 3 + rw + sw;
          r.en = (rd != 5'd0);
          r.data = model_load(f3, o, rdata);
        end
        busy_lo = a + 1;
        busy_hi = r.cyc - 1;
      end
      sb.push_back(r);
    end
    adv();
    ex_valid = 1'b0; is_flush = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    if (legal) begin
      repeat (rw) adv();
      dmem_req_ready = 1'b1;
      adv();
      dmem_req_ready = 1'b0;
      if (ld) begin
        repeat (sw) adv();
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = rdata;
        adv();
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = {$urandom, $urandom};
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    ex_valid = 1'b0; is_flush = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 64'd0; ex_result = 64'd0; ex_rd = 5'd0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("reset_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    chk("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("reset_wb_data", wb_data, 64'd0);
    reset = 1'b1;
    adv();
    chk_en = 1'b1;

    // hand-computed pins of the model
    chk("pin_lb", model_load(3'd0, 3, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_lbu", model_load(3'd4, 3, 64'h0000_0000_8000_0000), 64'h0000_0000_0000_0080);
    chk("pin_sh_wdata", model_wdata(64'hBEEF, 6), 64'hBEEF_0000_0000_0000);
    chk("pin_sh_wstrb", {56'd0, model_wstrb(3'd1, 6)}, 64'h0000_0000_0000_00C0);
    chk("pin_lw_sext", model_load(3'd2, 4, 64'h8765_4321_0000_0000), 64'hFFFF_FFFF_8765_4321);
    chk("pin_lhu", model_load(3'd5, 2, 64'h0000_0000_ABCD_0000), 64'h0000_0000_0000_ABCD);

    // non-memory back-to-back
    repeat (3) do_op(0, 0, 3'd0, 64'd0, 64'h1234, 5'd5, 0, 0, 64'd0, 0);
    // LB / LBU
    do_op(1, 0, 3'd0, 64'h1003, 64'd0, 5'd7, 0, 0, 64'h0000_0000_8000_0000, 0);
    do_op(1, 0, 3'd4, 64'h1003, 64'd0, 5'd8, 1, 2, 64'h0000_0000_8000_0000, 0);
    // SH with request stalled 4 cycles
    do_op(0, 1, 3'd1, 64'h2006, 64'hBEEF, 5'd3, 4, 0, 64'd0, 0);
    // misaligned LW, LD to x0
    do_op(1, 0, 3'd2, 64'h3002, 64'd0, 5'd9, 0, 0, 64'd0, 0);
    do_op(1, 0, 3'd3, 64'h3008, 64'd0, 5'd0, 0, 1, 64'hDEAD, 0);
    // illegal funct3
    do_op(1, 0, 3'd7, 64'h3000, 64'd0, 5'd4, 0, 0, 64'd0, 0);
    do_op(0, 1, 3'd4, 64'h3000, 64'd0, 5'd4, 0, 0, 64'd0, 0);
    // timeout with a late response, then boundary: response in the last cycle
    do_op(1, 0, 3'd3, 64'h5000, 64'd0, 5'd6, 0, 12, 64'h1111, 0);
    do_op(1, 0, 3'd3, 64'h5000, 64'd0, 5'd6, 1, TO, 64'h2222, 0);
    do_op(1, 0, 3'd2, 64'h5004, 64'd0, 5'd6, 0, TO - 1, 64'h7000_0000_0000_0000, 0);
    // flushed offers leave no trace
    do_op(0, 0, 3'd0, 64'd0, 64'h55, 5'd2, 0, 0, 64'd0, 1);
    do_op(1, 0, 3'd3, 64'h6000, 64'd0, 5'd2, 0, 0, 64'd0, 1);
    repeat (3) adv();

    // reset while a request is pending
    chk_en = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'd3;
    ex_addr = 64'h4000; ex_rd = 5'd1;
    adv();
    ex_valid = 1'b0;
    #2;
    chk("pre_reset_req_valid", {63'd0, dmem_req_valid}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_req_addr", dmem_req_addr, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    adv();
    adv();
    reset = 1'b1;
    adv();
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 64'hFFFF;
    sb.delete();
    busy_lo = 1; busy_hi = 0; req_lo = 1; req_hi = 0;
    adv();
    dmem_resp_valid = 1'b0;
    chk_en = 1'b1;
    repeat (3) adv();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      int kind;
      bit ld, st, fl;
      logic [2:0] f3;
      logic [4:0] rd;
      kind = $urandom_range(0, 9);
      ld = (kind >= 3 && kind <= 6);
      st = (kind >= 7);
      fl = ($urandom_range(0, 9) == 0);
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 3) != 0) f3 = {1'b0, f3[1:0]};
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(ld, st, f3, {$urandom, $urandom}, {$urandom, $urandom}, rd,
            $urandom_range(0, 3), $urandom_range(0, 10), {$urandom, $urandom}, fl);
    end

    repeat (15) adv();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wb_leftover actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
